// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the parametrised sync generator.
// Defaults describe standard 640x480@60 with active-low syncs.
package vga_timing_pkg;

  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;

  typedef struct packed {
    int display;
    int front;
    int sync;
    int back;
  } axis_timing_t;

  localparam axis_timing_t VGA640_H = '{VGA640_H_DISPLAY, VGA640_H_FRONT,
                                        VGA640_H_SYNC, VGA640_H_BACK};
  localparam axis_timing_t VGA640_V = '{VGA640_V_DISPLAY, VGA640_V_FRONT,
                                        VGA640_V_SYNC, VGA640_V_BACK};

  function automatic int axisTotal(input int display, input int front,
                                   input int sync, input int back);
    return display + front + sync + back;
  endfunction

  function automatic int syncStart(input int display, input int front);
    return display + front;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with advance enable, a wrap flag
// for the current position, and a sync decode registered alongside the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int DISPLAY    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96,
  parameter int W          = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_advance,
  output logic [W-1:0] o_pos,
  output logic         o_wrap,
  output logic         o_syncActive,
  output logic         o_activeNext
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] r_pos;
  logic         r_syncActive;
  logic [W-1:0] w_posNext;
  logic         w_syncNext;

  assign o_wrap = (r_pos == LAST);

  // Decode is taken from the value the counter is about to hold so that the
  // registered sync lines up with the registered position.
  always_comb begin
    w_posNext = r_pos;
    if (i_advance) begin
      w_posNext = o_wrap ? '0 : r_pos + W'(1);
    end
    w_syncNext = (SYNC_LEN > 0)
              && (int'(w_posNext) >= SYNC_START)
              && (int'(w_posNext) < SYNC_START + SYNC_LEN);
  end

  assign o_activeNext = (int'(w_posNext) < DISPLAY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos        <= LAST;
      r_syncActive <= 1'b0;
    end else if (i_advance) begin
      r_pos        <= w_posNext;
      r_syncActive <= w_syncNext;
    end
  end

  assign o_pos        = r_pos;
  assign o_syncActive = r_syncActive;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator: pixel clock-enable, programmable sync
// polarity, line/frame strobes and a completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = VGA640_H_DISPLAY,
  parameter int H_FRONT    = VGA640_H_FRONT,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BACK     = VGA640_H_BACK,
  parameter int V_DISPLAY  = VGA640_V_DISPLAY,
  parameter int V_FRONT    = VGA640_V_FRONT,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BACK     = VGA640_V_BACK,
  parameter int H_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int V_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [CNT_W-1:0]   hpos,
  output logic [CNT_W-1:0]   vpos,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int   H_TOTAL = axisTotal(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int   V_TOTAL = axisTotal(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam logic H_POL   = (H_SYNC_POL != 0);
  localparam logic V_POL   = (V_SYNC_POL != 0);

  logic w_hWrap, w_vWrap, w_hSyncAct, w_vSyncAct, w_hActNext, w_vActNext;
  logic w_vAdvance, w_frameWrap;
  logic r_displayOn, r_lineStart, r_frameStart, r_started;
  logic [FRAME_W-1:0] r_frameCnt;

  assign w_vAdvance  = pix_en & w_hWrap;
  assign w_frameWrap = w_vAdvance & w_vWrap;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .DISPLAY    (H_DISPLAY),
    .SYNC_START (syncStart(H_DISPLAY, H_FRONT)),
    .SYNC_LEN   (H_SYNC),
    .W          (CNT_W)
  ) uHAxis (
    .clk          (clk),
    .reset        (reset),
    .i_advance    (pix_en),
    .o_pos        (hpos),
    .o_wrap       (w_hWrap),
    .o_syncActive (w_hSyncAct),
    .o_activeNext (w_hActNext)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .DISPLAY    (V_DISPLAY),
    .SYNC_START (syncStart(V_DISPLAY, V_FRONT)),
    .SYNC_LEN   (V_SYNC),
    .W          (CNT_W)
  ) uVAxis (
    .clk          (clk),
    .reset        (reset),
    .i_advance    (w_vAdvance),
    .o_pos        (vpos),
    .o_wrap       (w_vWrap),
    .o_syncActive (w_vSyncAct),
    .o_activeNext (w_vActNext)
  );

  // The wrap out of the reset position only starts the first frame, so the
  // frame counter ignores it and counts completed frames from there on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_displayOn  <= 1'b0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
      r_started    <= 1'b0;
      r_frameCnt   <= '0;
    end else begin
      r_lineStart  <= w_vAdvance;
      r_frameStart <= w_frameWrap;
      if (pix_en) begin
        r_displayOn <= w_hActNext & w_vActNext;
        r_started   <= 1'b1;
      end
      if (w_frameWrap && r_started) begin
        r_frameCnt <= r_frameCnt + FRAME_W'(1);
      end
    end
  end

  assign hsync       = w_hSyncAct ? H_POL : ~H_POL;
  assign vsync       = w_vSyncAct ? V_POL : ~V_POL;
  assign display_on  = r_displayOn;
  assign line_start  = r_lineStart;
  assign frame_start = r_frameStart;
  assign frame_cnt   = r_frameCnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small 14x8 mode, run with both sync polarities
// side by side against an arithmetic model of screen position.
module tb_vga_timing_gen;

  localparam int H_TOT = 14;
  localparam int V_TOT = 8;
  localparam int FRAME_PIX = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic reset;
  logic pixEn;

  logic       hsA, vsA, dispA, lsA, fsA;
  logic [3:0] hA, vA;
  logic [1:0] fcA;
  logic       hsB, vsB, dispB, lsB, fsB;
  logic [3:0] hB, vB;
  logic [7:0] fcB;

  int checkCount = 0;
  int passCount  = 0;
  int n = 0;
  logic lastEn = 1'b0;

  typedef struct {
    logic en;
    int   h;
    int   v;
    logic ls;
    logic fs;
    logic d;
    logic hs;
    logic vs;
  } vec_t;

  vec_t tbl[17];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .CNT_W(4), .FRAME_W(2)
  ) dutA (
    .clk(clk), .reset(reset), .pix_en(pixEn),
    .hsync(hsA), .vsync(vsA), .display_on(dispA),
    .hpos(hA), .vpos(vA), .line_start(lsA), .frame_start(fsA),
    .frame_cnt(fcA)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .CNT_W(4), .FRAME_W(8)
  ) dutB (
    .clk(clk), .reset(reset), .pix_en(pixEn),
    .hsync(hsB), .vsync(vsB), .display_on(dispB),
    .hpos(hB), .vpos(vB), .line_start(lsB), .frame_start(fsB),
    .frame_cnt(fcB)
  );

  task automatic check(input string name, input int got, input int want);
    checkCount++;
    if (got == want) passCount++;
    else $display("[TB] FAIL %s got %0d want %0d", name, got, want);
  endtask

  // Model: n counts enabled edges since reset; edge k lands on pixel k-1 of
  // the raster, scanned row by row.
  task automatic checkOutput();
    int k, eh, ev, efc;
    logic ed, ehs, evs, els, efs;
    if (n == 0) begin
      eh = H_TOT - 1; ev = V_TOT - 1; efc = 0;
      ed = 0; ehs = 0; evs = 0; els = 0; efs = 0;
    end else begin
      k   = n - 1;
      eh  = k % H_TOT;
      ev  = (k / H_TOT) % V_TOT;
      efc = k / FRAME_PIX;
      ed  = (eh < 8) && (ev < 4);
      ehs = (eh >= 10) && (eh < 12);
      evs = (ev == 5);
      els = lastEn && (eh == 0);
      efs = els && (ev == 0);
    end
    check("hpos",        int'(hA),    eh);
    check("vpos",        int'(vA),    ev);
    check("display_on",  int'(dispA), int'(ed));
    check("hsync_low",   int'(hsA),   int'(!ehs));
    check("vsync_low",   int'(vsA),   int'(!evs));
    check("line_start",  int'(lsA),   int'(els));
    check("frame_start", int'(fsA),   int'(efs));
    check("frame_cnt_w2", int'(fcA),  efc % 4);
    check("hsync_high",  int'(hsB),   int'(ehs));
    check("vsync_high",  int'(vsB),   int'(evs));
    check("hpos_b",      int'(hB),    eh);
    check("display_on_b", int'(dispB), int'(ed));
    check("frame_cnt_w8", int'(fcB),  efc % 256);
  endtask

  task automatic applyStimulus(input logic en);
    pixEn = en;
    @(posedge clk);
    if (reset) begin
      n = 0;
      lastEn = 1'b0;
    end else begin
      lastEn = en;
      if (en) n++;
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    reset = 1'b1;
    pixEn = 1'b0;
    n = 0;
    lastEn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput();
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    tbl[0]  = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 4, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 5, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 6, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 7, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 8, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 9, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 11, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 12, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 13, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[16] = '{1'b1, 0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    doReset();
    check("rst_hpos", int'(hA), 13);
    check("rst_vpos", int'(vA), 7);
    check("rst_hsync", int'(hsA), 1);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].en);
      check($sformatf("tbl%0d_hpos", i), int'(hA), tbl[i].h);
      check($sformatf("tbl%0d_vpos", i), int'(vA), tbl[i].v);
      check($sformatf("tbl%0d_ls", i), int'(lsA), int'(tbl[i].ls));
      check($sformatf("tbl%0d_fs", i), int'(fsA), int'(tbl[i].fs));
      check($sformatf("tbl%0d_disp", i), int'(dispA), int'(tbl[i].d));
      check($sformatf("tbl%0d_hs", i), int'(hsA), int'(tbl[i].hs));
      check($sformatf("tbl%0d_vs", i), int'(vsA), int'(tbl[i].vs));
    end

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1);
      repeat (3) applyStimulus(1'b0);
    end

    for (int i = 0; i < 300; i++) applyStimulus(1'($urandom_range(0, 1)));

    $display("[TB] frame counting from fresh reset");
    doReset();
    applyStimulus(1'b1);
    check("first_fcnt", int'(fcA), 0);
    check("first_fs", int'(fsA), 1);
    repeat (FRAME_PIX) applyStimulus(1'b1);
    check("frame1_fs", int'(fsA), 1);
    check("frame1_fcnt", int'(fcA), 1);
    check("frame1_pos", int'(hA) + int'(vA), 0);
    repeat (3 * FRAME_PIX) applyStimulus(1'b1);
    check("frame4_fcnt_w2", int'(fcA), 0);
    check("frame4_fcnt_w8", int'(fcB), 4);

    $display("[TB] reset asserted mid-frame");
    guard = 0;
    while (!(n > 0 && ((n - 1) % H_TOT) == 5 && (((n - 1) / H_TOT) % V_TOT) == 2)
           && guard < 200) begin
      applyStimulus(1'b1);
      guard++;
    end
    check("reach_5_2_timeout", guard < 200, 1);
    #2 reset = 1'b1;
    n = 0;
    lastEn = 1'b0;
    #1 checkOutput();
    applyStimulus(1'b1);
    reset = 1'b0;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    check("post_rst_no_ls", int'(lsA), 0);
    applyStimulus(1'b1);
    check("post_rst_fs", int'(fsA), 1);
    check("post_rst_ls", int'(lsA), 1);
    applyStimulus(1'b0);
    check("post_rst_fs_width", int'(fsA), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
